spi_arb: RTL and testbench

SPI_ARB -- requirements
Module: spi_arb

---
 rtl/spi_arb_pkg.sv | 18 +
 rtl/spi_arb_rr_arb2.sv | 29 ++
 rtl/spi_arb.sv | 144 ++++++++++++++
 tb/tb_spi_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI bus arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        GUARD  = 2'd3
    } spi_arb_state_t;

    localparam int GUARD_CYC_DEF = 2;
    localparam int TMO_CYC_DEF   = 4095;

    // counter widths sized for the legal parameter ranges (1..15, 16..4095)
    localparam int GUARD_W = 4;
    localparam int TMO_W   = 12;

endpackage

// File: rtl/spi_arb_rr_arb2.sv
// Two-way round-robin arbiter. The pointer moves only when a grant is
// taken (advance), so the requester not served last wins a tie.
module rr_arb2
    import spi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_id,
    output logic       vld
);

    logic fav1;

    // grant decode: a lone request wins outright, a tie goes to the favoured side
    always_comb begin
        vld = |req;
        if (req == 2'b11) gnt_id = fav1;
        else              gnt_id = req[1];
    end

    // favour the other requester after each accepted grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       fav1 <= 1'b0;
        else if (advance) fav1 <= ~gnt_id;
    end

endmodule

// File: rtl/spi_arb.sv
// Arbiter sharing one 16-bit SPI master between the inertial sensor
// (requester 0) and the A2D (requester 1).
// Optional feature macro: SPI_ARB_TMO_EN adds a BUSY timeout that aborts
// with err, a done pulse and rd_data = 16'hFFFF.
//
// state  | meaning
// IDLE   | sample requests, latch winner and its command
// LAUNCH | one-cycle m_wrt start pulse to the SPI master
// BUSY   | wait for m_done (or timeout when enabled)
// GUARD  | GUARD_CYC forced idle cycles, requests not sampled
module spi_arb
    import spi_arb_pkg::*;
#(
    parameter int GUARD_CYC = GUARD_CYC_DEF,
    parameter int TMO_CYC   = TMO_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] cmd0,
    input  logic        req1,
    input  logic [15:0] cmd1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] rd_data,
    output logic        err,
    output logic        m_wrt,
    output logic [15:0] m_cmd,
    input  logic        m_done,
    input  logic [15:0] m_rd_data,
    input  logic        m_SS_n,
    output logic        SS0_n,
    output logic        SS1_n
);

    if (GUARD_CYC < 1 || GUARD_CYC > 15 || TMO_CYC < 16 || TMO_CYC > 4095) begin : g_bad_param
        $error("spi_arb: GUARD_CYC or TMO_CYC out of range");
    end

    spi_arb_state_t     state, state_nxt;
    logic               gnt_id;
    logic               arb_gnt, arb_vld, advance;
    logic               finish, tmo_hit;
    logic [GUARD_W-1:0] guard_cnt;
    logic [1:0]         done_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1, req0}),
        .advance (advance),
        .gnt_id  (arb_gnt),
        .vld     (arb_vld)
    );

`ifdef SPI_ARB_TMO_EN
    logic [TMO_W-1:0] tmo_cnt;

    // BUSY timeout down-counter, preloaded while the start pulse goes out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                tmo_cnt <= '0;
        else if (state == LAUNCH)                  tmo_cnt <= TMO_W'(TMO_CYC - 1);
        else if (state == BUSY && tmo_cnt != '0)   tmo_cnt <= tmo_cnt - 1'b1;
    end

    // a real m_done on the terminal cycle wins over the timeout
    assign tmo_hit = (state == BUSY) && (tmo_cnt == '0) && !m_done;

    // err pulses alongside the abort done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= tmo_hit;
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    assign finish = (state == BUSY) && (m_done || tmo_hit);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state decode and the start pulse
    always_comb begin
        state_nxt = state;
        m_wrt     = 1'b0;
        advance   = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_vld) begin
                    advance   = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                m_wrt     = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: begin
                if (finish) state_nxt = GUARD;
            end
            GUARD: begin
                if (guard_cnt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // grant/command latch, read-data capture, done pulses and guard timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_id    <= 1'b0;
            m_cmd     <= '0;
            rd_data   <= '0;
            done_q    <= '0;
            guard_cnt <= '0;
        end else begin
            done_q <= '0;
            if (advance) begin
                gnt_id <= arb_gnt;
                m_cmd  <= arb_gnt ? cmd1 : cmd0;
            end
            if (finish) begin
                rd_data   <= tmo_hit ? 16'hFFFF : m_rd_data;
                done_q    <= {gnt_id, ~gnt_id};
                guard_cnt <= GUARD_W'(GUARD_CYC - 1);
            end else if (state == GUARD && guard_cnt != '0) begin
                guard_cnt <= guard_cnt - 1'b1;
            end
        end
    end

    assign done0 = done_q[0];
    assign done1 = done_q[1];

    // route slave select only to the granted device while a transaction is open
    assign SS0_n = (state != IDLE && !gnt_id) ? m_SS_n : 1'b1;
    assign SS1_n = (state != IDLE &&  gnt_id) ? m_SS_n : 1'b1;

endmodule

// File: tb/tb_spi_arb.sv
// Randomized bench for spi_arb with a transaction-level reference model.
// Honors SPI_ARB_TMO_EN (timeout of 16 cycles when defined).
module tb_spi_arb;

    localparam int G = 2;
`ifdef SPI_ARB_TMO_EN
    localparam int  TMO    = 16;
    localparam bit  TMO_ON = 1'b1;
`else
    localparam int  TMO    = 16;
    localparam bit  TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] cmd0 = '0, cmd1 = '0;
    logic        done0, done1, err, m_wrt;
    logic [15:0] rd_data, m_cmd;
    logic        m_done = 1'b0;
    logic [15:0] m_rd_data = '0;
    logic        m_SS_n = 1'b1;
    logic        SS0_n, SS1_n;

    spi_arb #(.GUARD_CYC(G), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .cmd0(cmd0), .req1(req1), .cmd1(cmd1),
        .done0(done0), .done1(done1), .rd_data(rd_data), .err(err),
        .m_wrt(m_wrt), .m_cmd(m_cmd), .m_done(m_done), .m_rd_data(m_rd_data),
        .m_SS_n(m_SS_n), .SS0_n(SS0_n), .SS1_n(SS1_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: transaction bookkeeping in absolute cycle numbers
    int          cyc;
    bit          inflight;
    int          launch_cyc, idle_from;
    bit          cur_gnt, last_served;
    logic [15:0] exp_cmd, exp_rd;
    logic [1:0]  exp_done;
    bit          exp_err;

    // requester and SPI master behaviour
    bit          pend[2];
    bit          drop[2];
    logic [15:0] cmdv[2];
    bit          m_act;
    int          m_done_at;

    // stimulus knobs
    int          raise_pct[2];
    int          spur_pct;
    int          max_lat;
    bit          fixed_data;

    task automatic model_reset();
        inflight    = 1'b0;
        launch_cyc  = -100;
        idle_from   = 0;
        cur_gnt     = 1'b0;
        last_served = 1'b1;
        exp_cmd     = '0;
        exp_rd      = '0;
        exp_done    = '0;
        exp_err     = 1'b0;
        m_act       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0;
            drop[i] = 1'b0;
        end
    endtask

    // async reset: check reset values while asserted, release on a falling edge
    task automatic apply_reset();
        rst_n  = 1'b0;
        req0   = 1'b0;
        req1   = 1'b0;
        m_done = 1'b0;
        m_SS_n = 1'b0;
        #1;
        chk("rst_m_wrt", m_wrt, 0);
        chk("rst_m_cmd", m_cmd, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_err", err, 0);
        chk("rst_SS0_n", SS0_n, 1);
        chk("rst_SS1_n", SS1_n, 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // one clock cycle: check registered outputs, drive inputs, check routing, advance model
    task automatic step();
        bit          md, fin, tmo, win, active;
        logic [15:0] mdata, fdata;
        logic        dn;
        @(negedge clk);
        chk("m_wrt", m_wrt, (inflight && cyc == launch_cyc) ? 1 : 0);
        chk("m_cmd", m_cmd, exp_cmd);
        chk("done0", done0, exp_done[0]);
        chk("done1", done1, exp_done[1]);
        chk("rd_data", rd_data, exp_rd);
        chk("err", err, exp_err);

        for (int i = 0; i < 2; i++) begin
            dn = (i == 0) ? done0 : done1;
            if (drop[i]) begin
                pend[i] = 1'b0;
                drop[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(99) < raise_pct[i]) begin
                pend[i] = 1'b1;
            end
            if (dn === 1'b1) drop[i] = 1'b1;
            cmdv[i] = 16'($urandom);
        end
        if (fixed_data) cmdv[0][15:8] = 8'hA2;
        req0 = pend[0];
        req1 = pend[1];
        cmd0 = cmdv[0];
        cmd1 = cmdv[1];

        md     = 1'b0;
        mdata  = 16'($urandom);
        m_SS_n = m_act ? 1'b0 : 1'($urandom);
        if (m_act && cyc == m_done_at) begin
            md    = 1'b1;
            m_act = 1'b0;
            if (fixed_data) mdata = 16'h0034;
        end else if (!m_act && $urandom_range(99) < spur_pct) begin
            md = 1'b1;
        end
        if (m_wrt === 1'b1) begin
            m_act     = 1'b1;
            m_done_at = cyc + $urandom_range(max_lat, 1);
        end
        m_done    = md;
        m_rd_data = mdata;
        #1;
        active = inflight || (cyc < idle_from);
        chk("SS0_n", SS0_n, (active && cur_gnt == 1'b0) ? m_SS_n : 1'b1);
        chk("SS1_n", SS1_n, (active && cur_gnt == 1'b1) ? m_SS_n : 1'b1);

        exp_done = '0;
        exp_err  = 1'b0;
        fin      = 1'b0;
        tmo      = 1'b0;
        fdata    = mdata;
        if (inflight && cyc > launch_cyc) begin
            if (md) begin
                fin = 1'b1;
            end else if (TMO_ON && (cyc - launch_cyc) == TMO) begin
                fin   = 1'b1;
                tmo   = 1'b1;
                fdata = 16'hFFFF;
            end
        end else if (!inflight && cyc >= idle_from && (pend[0] || pend[1])) begin
            win         = (pend[0] && pend[1]) ? ~last_served : pend[1];
            last_served = win;
            cur_gnt     = win;
            exp_cmd     = cmdv[win];
            inflight    = 1'b1;
            launch_cyc  = cyc + 1;
        end
        if (fin) begin
            exp_done[cur_gnt] = 1'b1;
            exp_err           = tmo;
            exp_rd            = fdata;
            inflight          = 1'b0;
            idle_from         = cyc + 1 + G;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        bit reached;
        cyc        = 0;
        spur_pct   = 0;
        max_lat    = TMO_ON ? 20 : 6;
        fixed_data = 1'b0;
        raise_pct[0] = 0;
        raise_pct[1] = 0;
        #3;
        apply_reset();

        // requester 0 alone, fixed A2xx command and 0034 read data
        raise_pct[0] = 100;
        fixed_data   = 1'b1;
        run(14);
        fixed_data   = 1'b0;

        // both requesters permanently re-requesting: strict alternation
        raise_pct[1] = 100;
        run(60);

        // req1 always pending, req0 sporadic, spurious m_done pulses
        raise_pct[0] = 40;
        spur_pct     = 25;
        run(80);

        // reset in the middle of a BUSY phase
        spur_pct = 0;
        reached  = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            step();
            if (inflight && (cyc - 1) > launch_cyc) reached = 1'b1;
        end
        chk("reach_busy", reached, 1);
        #2;
        apply_reset();
        raise_pct[0] = 0;
        raise_pct[1] = 0;
        run(8);

        // free-running random traffic
        raise_pct[0] = 50;
        raise_pct[1] = 50;
        spur_pct     = 15;
        run(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
